// File: rtl/round_robin_mux_4_1.sv
`default_nettype none
// ============================================================================
// Module   : round_robin_mux_4_1
// Purpose  : Four-channel round-robin arbiter/mux feeding a single-entry
//            registered output stage with valid/ready handshaking.
//            A rotating priority pointer keeps the arbitration fair. The
//            output register can take a new word in the same cycle that the
//            old one is consumed, so throughput is one word per cycle.
// Ports    : clk        - clock, rising edge
//            rst        - synchronous active-high reset
//            in_valid   - per-channel valid (bit i qualifies d<i>)
//            in_ready   - per-channel ready, one-hot grant or zero
//            d0..d3     - channel data, WIDTH bits each
//            out_valid  - output register holds a word
//            out_ready  - downstream accepts the word
//            out_data   - registered selected data
//            out_sel    - index of the channel that supplied out_data
// Revision : 1.0 - initial release
// ============================================================================
module round_robin_mux_4_1 #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       in_valid,
   output logic [3:0]       in_ready,
   input  logic [WIDTH-1:0] d0,
   input  logic [WIDTH-1:0] d1,
   input  logic [WIDTH-1:0] d2,
   input  logic [WIDTH-1:0] d3,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       out_sel
);

   localparam logic [1:0] C_PTR_RESET = 2'd0;

   logic [1:0]       ptr_q,       ptr_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q,  out_data_d;
   logic [1:0]       out_sel_q,   out_sel_d;

   logic             w_can_accept;
   logic             w_found;
   logic [1:0]       w_grant;
   logic [1:0]       w_idx;
   logic             w_transfer;
   logic [WIDTH-1:0] w_sel_data;

   // The output register is free if empty or being drained this cycle.
   assign w_can_accept = ~out_valid_q | out_ready;

   // Rotating-priority search starting at ptr; the 2-bit sum wraps mod 4.
   always_comb begin
      w_found = 1'b0;
      w_grant = 2'd0;
      w_idx   = 2'd0;
      for (int k = 0; k < 4; k++) begin
         w_idx = ptr_q + k[1:0];
         if (!w_found && in_valid[w_idx]) begin
            w_found = 1'b1;
            w_grant = w_idx;
         end
      end
   end

   // Ready is withheld during reset so nothing is accepted on a reset edge.
   always_comb begin
      in_ready = 4'b0000;
      if (!rst && w_can_accept && w_found) begin
         in_ready[w_grant] = 1'b1;
      end
   end

   // A grant is only issued to a valid channel, so ready implies transfer.
   assign w_transfer = |(in_valid & in_ready);

   always_comb begin
      unique case (w_grant)
         2'd0:    w_sel_data = d0;
         2'd1:    w_sel_data = d1;
         2'd2:    w_sel_data = d2;
         default: w_sel_data = d3;
      endcase
   end

   always_comb begin
      ptr_d       = ptr_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      if (w_transfer) begin
         out_valid_d = 1'b1;
         out_data_d  = w_sel_data;
         out_sel_d   = w_grant;
         ptr_d       = w_grant + 2'd1;
      end else if (out_ready) begin
         // Word consumed with nothing new arriving: data/sel keep last value.
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q       <= C_PTR_RESET;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= 2'd0;
      end else begin
         ptr_q       <= ptr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;

endmodule
`default_nettype wire

// File: tb/tb_round_robin_mux_4_1.sv
`default_nettype none
// ============================================================================
// Module   : tb_round_robin_mux_4_1
// Purpose  : Directed self-checking bench for round_robin_mux_4_1 covering
//            reset, fairness rotation, single-channel streaming, drain,
//            backpressure and mid-operation reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_round_robin_mux_4_1;

   localparam int WIDTH = 4;

   logic             clk;
   logic             rst;
   logic [3:0]       in_valid;
   logic [3:0]       in_ready;
   logic [WIDTH-1:0] d0, d1, d2, d3;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [1:0]       out_sel;

   int checks;
   int failures;

   round_robin_mux_4_1 #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .d0        (d0),
      .d1        (d1),
      .d2        (d2),
      .d3        (d3),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sel   (out_sel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle after an input change.
   task automatic settle();
      #1;
   endtask

   task automatic check_out(input string tag, input logic v, input logic [WIDTH-1:0] d,
                            input logic [1:0] s);
      check_eq({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
      check_eq({tag, ".data"},  {28'd0, out_data},  {28'd0, d});
      check_eq({tag, ".sel"},   {30'd0, out_sel},   {30'd0, s});
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      rst       = 1'b1;
      in_valid  = 4'b0000;
      out_ready = 1'b0;
      d0 = 4'h0; d1 = 4'h0; d2 = 4'h0; d3 = 4'h0;

      // ---- reset: everything cleared, ready held low even with requests ----
      tick();
      in_valid = 4'b1111;
      settle();
      check_eq("rst.in_ready", {28'd0, in_ready}, 32'h0);
      tick();
      check_out("rst", 1'b0, 4'h0, 2'd0);

      // ---- all channels requesting: grants rotate 0,1,2,3,0,1,2,3 ----
      rst = 1'b0;
      d0 = 4'h1; d1 = 4'h2; d2 = 4'h3; d3 = 4'h4;
      out_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         logic [3:0] exp_rdy;
         exp_rdy = 4'b0001 << (c % 4);
         settle();
         check_eq($sformatf("rr%0d.in_ready", c), {28'd0, in_ready}, {28'd0, exp_rdy});
         tick();
         check_out($sformatf("rr%0d", c), 1'b1, 4'((c % 4) + 1), 2'(c % 4));
      end

      // ---- only channel 2 requesting: it wins every cycle ----
      in_valid = 4'b0100;
      d2 = 4'hA;
      for (int c = 0; c < 3; c++) begin
         settle();
         check_eq($sformatf("ch2_%0d.in_ready", c), {28'd0, in_ready}, 32'h4);
         tick();
         check_out($sformatf("ch2_%0d", c), 1'b1, 4'hA, 2'd2);
      end

      // ---- drain with no requests: valid drops, data/sel hold ----
      in_valid = 4'b0000;
      tick();
      check_out("drain", 1'b0, 4'hA, 2'd2);

      // ---- load d1=5 (ptr=3, only ch1 valid), then backpressure ----
      d0 = 4'h1; d1 = 4'h5; d2 = 4'h3; d3 = 4'h4;
      in_valid  = 4'b0010;
      out_ready = 1'b0;
      settle();
      check_eq("load1.in_ready", {28'd0, in_ready}, 32'h2);
      tick();
      check_out("load1", 1'b1, 4'h5, 2'd1);
      in_valid = 4'b1111;
      for (int c = 0; c < 5; c++) begin
         settle();
         check_eq($sformatf("bp%0d.in_ready", c), {28'd0, in_ready}, 32'h0);
         tick();
         check_out($sformatf("bp%0d", c), 1'b1, 4'h5, 2'd1);
      end
      out_ready = 1'b1;
      settle();
      check_eq("bp_rel.in_ready", {28'd0, in_ready}, 32'h4);
      tick();
      check_out("bp_rel", 1'b1, 4'h3, 2'd2);

      // ---- single word then idle: valid for exactly one cycle ----
      in_valid = 4'b0000;
      tick();
      check_out("idle0", 1'b0, 4'h3, 2'd2);
      tick();
      check_out("idle1", 1'b0, 4'h3, 2'd2);

      // ---- mid-operation reset with a word held and ptr nonzero ----
      in_valid = 4'b0100;
      tick();
      check_out("pre_rst", 1'b1, 4'h3, 2'd2);
      rst       = 1'b1;
      in_valid  = 4'b1111;
      out_ready = 1'b0;
      settle();
      check_eq("midrst.in_ready", {28'd0, in_ready}, 32'h0);
      tick();
      check_out("midrst", 1'b0, 4'h0, 2'd0);
      rst       = 1'b0;
      out_ready = 1'b1;
      settle();
      check_eq("post_rst.in_ready", {28'd0, in_ready}, 32'h1);
      tick();
      check_out("post_rst", 1'b1, 4'h1, 2'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/round_robin_mux_4_1.md
ROUND_ROBIN_MUX_4_1 -- requirements
Module: round_robin_mux_4_1

Interface
- REQ-001 SHALL have parameter: WIDTH, 4, width of each data channel and of out_data.
- REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
- REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
- REQ-004 SHALL have port: in_valid  input  4  per-channel valid; bit i qualifies d<i>.
- REQ-005 SHALL have port: in_ready  output  4  per-channel ready; at most one bit set (one-hot grant or zero).
- REQ-006 SHALL have ports: d0, d1, d2, d3  input  WIDTH each  channel data.
- REQ-007 SHALL have port: out_valid  output  1  output register holds a word.
- REQ-008 SHALL have port: out_ready  input  1  downstream accepts the word.
- REQ-009 SHALL have port: out_data  output  WIDTH  registered selected data.
- REQ-010 SHALL have port: out_sel  output  2  index of the channel that supplied out_data.

Function
- REQ-011 SHALL hold a 1-entry output register (out_valid, out_data, out_sel) and a 2-bit priority pointer ptr.
- REQ-012 SHALL define can_accept = ~out_valid | out_ready.
- REQ-013 SHALL select grant index g as the first i with in_valid[i]=1, searched in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- REQ-014 SHALL drive in_ready[g]=1 and all other bits 0 when can_accept=1 and in_valid!=0; otherwise in_ready=4'b0000.
- REQ-015 SHALL treat in_ready as a combinational function of in_valid, out_valid, out_ready and ptr only; it SHALL NOT depend on d0..d3.
- REQ-016 SHALL define a transfer on channel g as in_valid[g] & in_ready[g]; on that cycle's edge it SHALL load out_data<=d<g>, out_sel<=g, out_valid<=1 (latency: 1 cycle input-to-output).
- REQ-017 SHALL update ptr<=(g+1) mod 4 on every transfer, and leave ptr unchanged otherwise (wrap-around: g=3 gives ptr=0).
- REQ-018 SHALL, when out_valid=1 and out_ready=1 with no transfer in the same cycle, clear out_valid<=0; out_data and out_sel hold their last values.
- REQ-019 SHALL, when out_valid=1, out_ready=1 and a transfer occurs in the same cycle, load the new word with out_valid staying 1 (no bubble; full throughput of one word per cycle).
- REQ-020 SHALL, when out_valid=1 and out_ready=0, hold out_valid, out_data, out_sel stable and drive in_ready=0 (backpressure).
- REQ-021 SHALL not lose or duplicate any word: each transfer appears exactly once at the output and is consumed on exactly one cycle with out_valid & out_ready.
- REQ-022 SHALL guarantee fairness: with all four in_valid held at 1 and out_ready=1, grants SHALL cycle 0,1,2,3,0,...
- REQ-023 SHALL allow an upstream channel to deassert in_valid at any time without handshake completion; a not-granted channel loses nothing.
- REQ-024 SHALL implement the data selection with a 4:1 selection by g; no other storage beyond REQ-011.

Reset
- REQ-025 SHALL, on a clk edge with rst=1, set out_valid=0, out_data=0, out_sel=0, ptr=0, regardless of any other input.
- REQ-026 SHALL drive in_ready=0 during any cycle in which rst=1, so no transfer occurs on a reset cycle.
- REQ-027 SHALL discard a word held in the output register when rst asserts mid-operation; the first cycle after rst deasserts starts with priority at channel 0.

Verification
- REQ-028 Reset then in_valid=4'b1111, d0..d3=1,2,3,4, out_ready=1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3 with out_data 1,2,3,4,1,2,3,4, out_valid=1 from cycle 2 onward without bubbles.
- REQ-029 Only in_valid[2]=1, d2=4'hA, out_ready=1 -> in_ready=4'b0100 each cycle, out_data=4'hA, out_sel=2 every cycle after the first; ptr stays 3 so channel 2 still wins.
- REQ-030 Load one word (d1=4'h5), then out_ready=0 for 5 cycles with in_valid=4'b1111 -> in_ready=0, out_data=4'h5, out_sel=1, out_valid=1 stable all 5 cycles; on out_ready=1 next grant is channel 2.
- REQ-031 Single word accepted, in_valid then 0, out_ready=1 -> out_valid=1 for exactly one cycle, then 0 with out_data unchanged.
- REQ-032 rst=1 asserted while out_valid=1 and in_valid=4'b1111 -> next cycle out_valid=0, out_data=0, out_sel=0, in_ready=0 during reset; after release first grant is channel 0.
- REQ-033 Random in_valid/out_ready/data for 10000 cycles against a scoreboard -> every accepted word observed once in order, in_ready always zero or one-hot, no channel with continuous in_valid waits more than 3 grants.
